// File: rtl/liteeth_sram_tx_reader.sv
// Streams a frame out of a word-wide SRAM ring as 32-bit words.
// Reads are paced by a 2-entry output FIFO so that at most two words are ever held or in flight.
module liteeth_sram_tx_reader #(
  parameter int ADDR_WIDTH = 9,
  parameter int WORD_DEPTH = 384,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  sram_csb,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [31:0]           sram_dout,
  output logic                  src_valid,
  input  logic                  src_ready,
  output logic [31:0]           src_data,
  output logic                  src_last,
  output logic [3:0]            src_last_be,
  output logic                  busy,
  output logic                  err_len
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [31:0]           MAX_LEN   = 32'(4 * WORD_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [LEN_WIDTH-1:0]  issue_left;
  logic [LEN_WIDTH-1:0]  out_left;
  logic [3:0]            be_reg;
  logic                  rd_pending;
  logic [31:0]           fifo_mem [2];
  logic                  wptr;
  logic                  rptr;
  logic [1:0]            count;
  logic                  err_reg;

  logic                  accept;
  logic                  len_bad;
  logic                  pop;
  logic                  issue;
  logic [LEN_WIDTH:0]    len_round;
  logic [LEN_WIDTH-1:0]  num_words;
  logic [3:0]            last_be;
  logic [2:0]            occupancy;

  assign cmd_ready = rst_n && (state == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign len_bad   = (cmd_len == '0) || (32'(cmd_len) > MAX_LEN);
  assign len_round = {1'b0, cmd_len} + (LEN_WIDTH + 1)'(3);
  assign num_words = {1'b0, len_round[LEN_WIDTH:2]};

  always_comb begin
    last_be = 4'b1111;
    case (cmd_len[1:0])
      2'd1:    last_be = 4'b0001;
      2'd2:    last_be = 4'b0011;
      2'd3:    last_be = 4'b0111;
      default: last_be = 4'b1111;
    endcase
  end

  assign src_valid = (count != 2'd0);
  assign pop       = src_valid && src_ready;
  // A pop this cycle frees a slot in time for the word we are about to request.
  assign occupancy = {1'b0, count} + {2'b0, rd_pending} - {2'b0, pop};
  assign issue     = (state == S_READ) && (issue_left != '0) && (occupancy < 3'd2);

  assign sram_csb    = !issue;
  assign sram_addr   = addr_reg;
  assign src_data    = src_valid ? fifo_mem[rptr] : 32'd0;
  assign src_last    = src_valid && (out_left == LEN_WIDTH'(1));
  assign src_last_be = !src_valid ? 4'b0000 : (src_last ? be_reg : 4'b1111);
  assign busy        = (state != S_IDLE);
  assign err_len     = err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      addr_reg    <= '0;
      issue_left  <= '0;
      out_left    <= '0;
      be_reg      <= 4'b0000;
      rd_pending  <= 1'b0;
      fifo_mem[0] <= 32'd0;
      fifo_mem[1] <= 32'd0;
      wptr        <= 1'b0;
      rptr        <= 1'b0;
      count       <= 2'd0;
      err_reg     <= 1'b0;
    end else begin
      err_reg    <= accept && len_bad;
      rd_pending <= issue;
      count      <= count + {1'b0, rd_pending} - {1'b0, pop};
      if (rd_pending) begin
        fifo_mem[wptr] <= sram_dout;
        wptr           <= ~wptr;
      end
      if (pop) begin
        rptr     <= ~rptr;
        out_left <= out_left - LEN_WIDTH'(1);
      end
      if (issue) begin
        addr_reg   <= (addr_reg == LAST_ADDR) ? '0 : addr_reg + ADDR_WIDTH'(1);
        issue_left <= issue_left - LEN_WIDTH'(1);
      end
      case (state)
        S_IDLE: begin
          if (accept && !len_bad) begin
            state      <= S_READ;
            addr_reg   <= cmd_addr;
            issue_left <= num_words;
            out_left   <= num_words;
            be_reg     <= last_be;
          end
        end
        S_READ: begin
          if (issue && (issue_left == LEN_WIDTH'(1))) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (pop && (out_left == LEN_WIDTH'(1))) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_liteeth_sram_tx_reader.sv
// Scoreboard bench for liteeth_sram_tx_reader: stimulus pushes expected reads and words,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_liteeth_sram_tx_reader;

  localparam int AW = 9;
  localparam int DEPTH = 384;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          sram_csb;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_dout = 32'd0;
  logic          src_valid;
  logic          src_ready = 1'b1;
  logic [31:0]   src_data;
  logic          src_last;
  logic [3:0]    src_last_be;
  logic          busy;
  logic          err_len;

  liteeth_sram_tx_reader #(.ADDR_WIDTH(AW), .WORD_DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .sram_csb(sram_csb), .sram_addr(sram_addr),
    .sram_dout(sram_dout), .src_valid(src_valid), .src_ready(src_ready),
    .src_data(src_data), .src_last(src_last), .src_last_be(src_last_be),
    .busy(busy), .err_len(err_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic [3:0]  be;
  } exp_t;

  logic [31:0] sram [DEPTH];
  exp_t exp_q [$];
  int   addr_q [$];
  int   total = 0;
  int   bad = 0;
  int   issued = 0;
  int   popped = 0;
  int   hs_cnt = 0;
  int   err_cnt = 0;
  int   exp_err = 0;
  int   ready_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // SRAM read port: data appears one cycle after a chip-select-low edge.
  always @(posedge clk) begin
    if (!sram_csb) sram_dout <= (int'(sram_addr) < DEPTH) ? sram[sram_addr] : 32'hdeadbeef;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: src_ready = 1'b1;
        1: src_ready = ~src_ready;
        2: src_ready = ($urandom_range(0, 3) != 0);
        default: src_ready = 1'b0;
      endcase
    end
  end

  exp_t        e_cur;
  int          a_cur;
  logic        held_valid = 1'b0;
  logic [31:0] held_data;
  logic        held_last;
  logic [3:0]  held_be;

  always @(negedge clk) begin
    if (!rst_n) begin
      issued = 0;
      popped = 0;
      held_valid = 1'b0;
    end else begin
      if (!sram_csb) begin
        chk("outstanding_le2", 32'((issued - popped - ((src_valid && src_ready) ? 1 : 0)) < 2), 32'd1);
        if (addr_q.size() == 0) chk("unexpected_read", {23'd0, sram_addr}, 32'hffffffff);
        else begin
          a_cur = addr_q.pop_front();
          chk("read_addr", {23'd0, sram_addr}, a_cur);
        end
        issued++;
      end
      if (held_valid) begin
        chk("stall_valid", {31'd0, src_valid}, 32'd1);
        chk("stall_data", src_data, held_data);
        chk("stall_last_be", {27'd0, src_last, src_last_be}, {27'd0, held_last, held_be});
      end
      held_valid = src_valid && !src_ready;
      held_data = src_data;
      held_last = src_last;
      held_be = src_last_be;
      if (src_valid && src_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", src_data, 32'hffffffff);
        else begin
          e_cur = exp_q.pop_front();
          chk("word_data", src_data, e_cur.d);
          chk("word_last_be", {27'd0, src_last, src_last_be}, {27'd0, e_cur.l, e_cur.be});
        end
        popped++;
        hs_cnt++;
      end
      if (err_len) err_cnt++;
    end
  end

  // Expected behaviour straight from the frame description: word i of a frame at address a is
  // the ring word (a+i) mod DEPTH, and the final word's enables cover len mod 4 bytes.
  task automatic send(input int a, input int len);
    int nw;
    exp_t e;
    logic [3:0] be_tab [4];
    be_tab[0] = 4'b1111; be_tab[1] = 4'b0001; be_tab[2] = 4'b0011; be_tab[3] = 4'b0111;
    if (len == 0 || len > 4 * DEPTH) exp_err++;
    else begin
      nw = (len + 3) / 4;
      for (int i = 0; i < nw; i++) begin
        addr_q.push_back((a + i) % DEPTH);
        e.d = sram[(a + i) % DEPTH];
        e.l = (i == nw - 1);
        e.be = (i == nw - 1) ? be_tab[len % 4] : 4'b1111;
        exp_q.push_back(e);
      end
    end
    cmd_valid = 1'b1;
    cmd_addr = AW'(a);
    cmd_len = LW'(len);
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (cmd_ready) break;
      if (t == 4999) chk("cmd_ready_timeout", 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int t = 0; t < 8000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && addr_q.size() == 0 && !busy) break;
      if (t == 7999) chk("frame_timeout", 32'(exp_q.size()), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_csb", {31'd0, sram_csb}, 32'd1);
    chk("rst_addr", {23'd0, sram_addr}, 32'd0);
    chk("rst_valid_last", {30'd0, src_valid, src_last}, 32'd0);
    chk("rst_be", {28'd0, src_last_be}, 32'd0);
    chk("rst_data", src_data, 32'd0);
    chk("rst_busy_err", {30'd0, busy, err_len}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0;
    int a;
    int len;
    for (int i = 0; i < DEPTH; i++) sram[i] = $urandom;
    #1;
    chk_reset_outputs();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Basic frame with latency check: accept at edge N, read at N+1, valid after N+2.
    ready_mode = 0;
    send(32'h010, 8);
    chk("lat_csb_n", {31'd0, sram_csb}, 32'd0);
    chk("lat_valid_n", {31'd0, src_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_valid_n1", {31'd0, src_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_valid_n2", {31'd0, src_valid}, 32'd1);
    wait_done();
    chk("ready_after_frame", {31'd0, cmd_ready}, 32'd1);

    // Ring wrap with a 1-byte tail.
    send(32'h17F, 9);
    wait_done();

    // Rejected lengths.
    e0 = err_cnt;
    send(0, 0);
    chk("err_pulse0", {31'd0, err_len}, 32'd1);
    send(0, 1537);
    chk("err_pulse1", {30'd0, err_len, busy}, 32'd2);
    repeat (4) @(posedge clk);
    #1;
    chk("err_count", 32'(err_cnt - e0), 32'd2);

    // Full ring with alternating backpressure.
    ready_mode = 1;
    send(0, 1536);
    wait_done();

    // Long stall after the first word.
    ready_mode = 0;
    e0 = hs_cnt;
    send(32'h0A0, 64);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (hs_cnt != e0) break;
    end
    ready_mode = 3;
    repeat (10) @(posedge clk);
    #1;
    chk("stall_csb_high", {31'd0, sram_csb}, 32'd1);
    chk("stall_fifo_full", {31'd0, src_valid}, 32'd1);
    ready_mode = 0;
    wait_done();

    // Reset mid-frame, then a fresh frame from its own address.
    send(5, 64);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {30'd0, cmd_ready, src_valid}, 32'd2);
    @(posedge clk);
    #1;
    send(32'h040, 20);
    wait_done();

    // Random frames, random backpressure, occasional bad lengths.
    ready_mode = 2;
    for (int k = 0; k < 14; k++) begin
      a = $urandom_range(0, DEPTH - 1);
      if (k % 5 == 4) len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1537, 2047);
      else len = $urandom_range(1, 200);
      send(a, len);
      wait_done();
    end
    repeat (3) @(posedge clk);
    #1;
    chk("err_total", err_cnt, exp_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
